// File: rtl/note_tone_gen.sv
// note_tone_gen
//   Speaker back end for the FPGA piano. Brings the beat-domain note code into
//   the CLK domain, debounces it, and generates a square wave whose pitch only
//   changes on half-period boundaries so no runt pulse ever reaches SPEAKER.
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   asynchronous active-high reset
//   NOTE_IN[3:0] in   note code (0 none, 1..8 = C4..C5, 9..15 treated as none)
//   MUTE         in   synchronous mute, overrides everything
//   SPEAKER      out  square-wave audio
//   TONE_ON      out  high while a tone is being generated
//   NOTE_PLAYING out  code currently being generated, 0 when idle
module note_tone_gen #(
    parameter int STABLE_CYCLES = 4,
    parameter int DIV_SHIFT     = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] NOTE_IN,
    input  logic       MUTE,
    output logic       SPEAKER,
    output logic       TONE_ON,
    output logic [3:0] NOTE_PLAYING
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    function automatic logic [3:0] map_code(input logic [3:0] code);
        return (code > 4'd8) ? 4'd0 : code;
    endfunction

    // Clocks per speaker level; the clamp keeps heavily shifted simulation
    // builds from producing a zero or one-clock half period.
    function automatic logic [17:0] half_cnt(input logic [3:0] code);
        logic [17:0] base;
        logic [17:0] shifted;
        case (code)
            4'd1:    base = 18'd191110;
            4'd2:    base = 18'd170265;
            4'd3:    base = 18'd151685;
            4'd4:    base = 18'd143172;
            4'd5:    base = 18'd127551;
            4'd6:    base = 18'd113636;
            4'd7:    base = 18'd101239;
            4'd8:    base = 18'd95557;
            default: base = 18'd0;
        endcase
        shifted = base >> DIV_SHIFT;
        if (shifted < 18'd2) shifted = 18'd2;
        return shifted;
    endfunction

    logic [3:0]        sync1_q, sync2_q, sync2_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [3:0]        acc_q, acc_d;
    logic [0:0]        state_q, state_d;
    logic [17:0]       cnt_q, cnt_d;
    logic              spk_q, spk_d;
    logic [3:0]        np_q, np_d;

    // Input path. The stability count ages the value about to sit in sync2_q,
    // so it compares the incoming (mapped) code with the current note_s; this
    // puts acceptance exactly 2 + STABLE_CYCLES clocks after sampling.
    always_comb begin
        sync2_d = map_code(sync1_q);
        if (sync2_d != sync2_q) begin
            stab_d = '0;
        end else if (stab_q == STAB_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + 1'b1;
        end
        acc_d = acc_q;
        if ((stab_q == STAB_MAX) && (sync2_q != acc_q)) begin
            acc_d = sync2_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            stab_q  <= '0;
            acc_q   <= '0;
        end else begin
            sync1_q <= NOTE_IN;
            sync2_q <= sync2_d;
            stab_q  <= stab_d;
            acc_q   <= acc_d;
        end
    end

    // Tone FSM. Pitch and stop decisions are taken only when cnt_q expires,
    // which is what guarantees full-length levels on SPEAKER.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        spk_d   = spk_q;
        np_d    = np_q;
        if (MUTE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            spk_d   = 1'b0;
            np_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    spk_d = 1'b0;
                    np_d  = '0;
                    if (acc_q != 4'd0) begin
                        state_d = ST_PLAY;
                        spk_d   = 1'b1;
                        cnt_d   = half_cnt(acc_q) - 18'd1;
                        np_d    = acc_q;
                    end
                end
                ST_PLAY: begin
                    if (cnt_q != 18'd0) begin
                        cnt_d = cnt_q - 18'd1;
                    end else if (acc_q == np_q) begin
                        spk_d = ~spk_q;
                        cnt_d = half_cnt(np_q) - 18'd1;
                    end else if (acc_q != 4'd0) begin
                        spk_d = ~spk_q;
                        np_d  = acc_q;
                        cnt_d = half_cnt(acc_q) - 18'd1;
                    end else begin
                        state_d = ST_IDLE;
                        spk_d   = 1'b0;
                        np_d    = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    spk_d   = 1'b0;
                    np_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            spk_q   <= 1'b0;
            np_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spk_q   <= spk_d;
            np_q    <= np_d;
        end
    end

    assign SPEAKER      = spk_q;
    assign TONE_ON      = (state_q == ST_PLAY);
    assign NOTE_PLAYING = np_q;

endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Audio back end for the FPGA piano. It consumes the 4-bit note code produced by the auto-play sequencers and the keyboard scanner, and drives a glitch-free square wave on the speaker pin. The note code comes from the slow beat-clock domain, so the block synchronises it and debounces it into the system-clock domain. Pitch changes are applied only at half-period boundaries, so the speaker never emits a runt pulse.

## Interface
Parameters:
- STABLE_CYCLES, 4: number of consecutive system clocks a synchronised code must hold before it is accepted. Legal range is ≥1.
- DIV_SHIFT, 0: right-shift applied to every half-period count. Use 0 in hardware and 10 in simulation. A shifted count below 2 is clamped to 2.

Ports:
- CLK, input, 1: 100 MHz system clock. All logic is on the rising edge.
- RESET, input, 1: reset, asynchronous, active-high.
- NOTE_IN, input, 4: note code, asynchronous to CLK. 0 = none, 1 = C4, 2 = D4, 3 = E4, 4 = F4, 5 = G4, 6 = A4, 7 = B4, 8 = C5. Codes 9–15 are treated as none.
- MUTE, input, 1: synchronous mute, active-high.
- SPEAKER, output, 1: square-wave audio.
- TONE_ON, output, 1: high while in state PLAY.
- NOTE_PLAYING, output, 4: code currently being generated. It reads 0 in IDLE.

## Operation
Input path:
- NOTE_IN passes through a 2-flop synchroniser to produce note_s. Invalid codes are mapped to 0 at this point.
- A stability counter tracks note_s. It clears to 0 when note_s differs from its previous value, otherwise it increments and saturates at STABLE_CYCLES-1.
- When the count equals STABLE_CYCLES-1 and note_s ≠ accepted, the block loads accepted ← note_s.

Half-period table, HALF = round(1e8/(2f)) >> DIV_SHIFT:
- C4 191110, D4 170265, E4 151685, F4 143172.
- G4 127551, A4 113636, B4 101239, C5 95557.
- An 18-bit down-counter cnt holds the count.

FSM:
- IDLE: SPEAKER = 0, cnt = 0. If accepted ≠ 0 and MUTE = 0, the next clock sets SPEAKER ← 1, cnt ← HALF(accepted)-1, NOTE_PLAYING ← accepted, and moves to PLAY.
- PLAY with cnt > 0: cnt decrements.
- PLAY with cnt = 0, when accepted = NOTE_PLAYING: toggle SPEAKER and reload cnt ← HALF(NOTE_PLAYING)-1.
- PLAY with cnt = 0, when accepted ≠ 0 and differs from NOTE_PLAYING: toggle SPEAKER, set NOTE_PLAYING ← accepted, and reload with the new HALF.
- PLAY with cnt = 0, when accepted = 0: SPEAKER ← 0, NOTE_PLAYING ← 0, go to IDLE.
- MUTE = 1 in any state has priority over everything. The next clock forces SPEAKER ← 0, NOTE_PLAYING ← 0, cnt ← 0 and state IDLE, and the block stays in IDLE while MUTE is held.
- The synchroniser and accepted keep tracking the input during MUTE.

## Timing
- Reset values: SPEAKER 0, TONE_ON 0, NOTE_PLAYING 0, state IDLE, cnt 0, accepted 0, both synchroniser flops 0, stability count 0.
- Latency from NOTE_IN being sampled stable to accepted updating is 2 + STABLE_CYCLES clocks.
- From IDLE, SPEAKER rises 1 clock after accepted updates.
- In steady PLAY, each SPEAKER level lasts exactly HALF clocks, so the period is 2·HALF.
- A pitch change completes the current half-period at the old pitch, then runs a full half-period at the new pitch.
- A change to none finishes the current half-period before SPEAKER drops. If SPEAKER was already 0, it simply stays 0.
- A code that toggles faster than STABLE_CYCLES is never accepted, and the output is unaffected.
- Releasing MUTE with accepted ≠ 0 restarts playback from IDLE on the next clock.
- Asserting RESET mid-period returns all outputs to 0 immediately, without waiting for a clock.
- Back-to-back notes separated by a single beat of none pass through IDLE, giving audible articulation.

## Test plan
- Reset, then DIV_SHIFT=10, STABLE_CYCLES=4, NOTE_IN=1 at t0 → SPEAKER rises 7 clocks later. It then toggles every 186 clocks, with TONE_ON=1 and NOTE_PLAYING=1.
- While playing E (code 3, HALF=148), switch NOTE_IN to A (code 6) mid-half-period → the current 148-clock level completes, the next level lasts 110 clocks, and NOTE_PLAYING=6 from that boundary.
- Hold NOTE_IN=5 for 3 clocks, then return it to 0 → accepted never changes, and SPEAKER, TONE_ON and NOTE_PLAYING stay 0.
- Play C4, then set NOTE_IN=12 → the code is treated as none, the current half-period completes, SPEAKER goes to 0, TONE_ON goes to 0, and the block is in IDLE.
- Play D4 and assert MUTE for 20 clocks → SPEAKER goes to 0 on the next clock and stays 0 while MUTE is high. On release, SPEAKER rises 1 clock later with HALF=166.
- Play G4, then pulse RESET asynchronously between clock edges → all outputs read 0 before the next edge, and playback resumes 7 clocks after RESET deasserts, since NOTE_IN is still 5.
